// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter: round-robin push-port sharing for one FIFO with optional burst locking and source-id tagging
module fifo_push_arbiter #(
  parameter int N_REQ = 4,
  parameter int DATA_WIDTH = 8,
  parameter int MAX_BURST = 4,
  localparam int ID_W = N_REQ > 1 ? $clog2(N_REQ) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_REQ-1:0]            req_valid,
  input  logic [N_REQ-1:0]            req_last,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]            req_ready,
  input  logic                        fifo_full,
  output logic                        fifo_push,
  output logic [ID_W+DATA_WIDTH-1:0]  fifo_data,
  output logic [ID_W-1:0]             grant_id,
  output logic                        locked
);
  localparam int CW = $clog2(MAX_BURST) + 1;
  typedef enum logic {IDLE, LOCKED} state_t;
  state_t state;
  logic [ID_W-1:0] rr_ptr, owner, win, idx, nxt;
  logic [CW-1:0] beat_cnt;
  logic [DATA_WIDTH-1:0] pay [N_REQ];
  logic idle, any, last_w;
  for (genvar i = 0; i < N_REQ; i++) begin : g_pay
    assign pay[i] = req_data[i*DATA_WIDTH +: DATA_WIDTH];
  end
  // descending scan so the candidate closest to rr_ptr is written last and wins
  always_comb begin
    win = '0;
    idx = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = ID_W'((int'(rr_ptr) + k) % N_REQ);
      win = req_valid[idx] ? idx : win;
    end
  end
  assign idle = state == IDLE;
  assign any = |req_valid;
  assign grant_id = idle ? win : owner;
  assign fifo_push = !rst && !fifo_full && (idle ? any : req_valid[owner]);
  assign req_ready = fifo_push ? N_REQ'(1) << grant_id : '0;
  assign fifo_data = {grant_id, pay[grant_id]};
  assign locked = !rst && !idle;
  assign last_w = req_last[grant_id];
  assign nxt = grant_id == ID_W'(N_REQ - 1) ? '0 : grant_id + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rr_ptr <= '0;
      owner <= '0;
      beat_cnt <= '0;
    end else if (fifo_push) begin
      if (idle) begin
        if (!last_w && MAX_BURST > 1) begin
          state <= LOCKED;
          owner <= grant_id;
          beat_cnt <= CW'(1);
        end else rr_ptr <= nxt;
      end else if (last_w || beat_cnt + CW'(1) == CW'(MAX_BURST)) begin
        state <= IDLE;
        rr_ptr <= nxt;
        beat_cnt <= '0;
      end else beat_cnt <= beat_cnt + CW'(1);
    end
  end
endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter: directed scenario tables plus randomized run against a burst-level reference model
module tb_fifo_push_arbiter;
  localparam int N = 4, DW = 8, MB = 4, IW = 2;
  logic clk = 0, rst, full, push, locked;
  logic [N-1:0] valid, last, ready;
  logic [N*DW-1:0] data;
  logic [IW+DW-1:0] fdata;
  logic [IW-1:0] gid;
  int checks = 0, errors = 0;
  bit mlock;
  int mrr, mown, mbeats;
  int seq [N];

  always #5 clk = ~clk;

  fifo_push_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(valid), .req_last(last), .req_data(data),
    .req_ready(ready), .fifo_full(full), .fifo_push(push), .fifo_data(fdata),
    .grant_id(gid), .locked(locked));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int c);
    for (int i = 0; i < N; i++) data[i*DW +: DW] = DW'(16 * (i + 1) + c);
  endtask

  task automatic apply_reset;
    rst = 1; valid = '0; last = '0; full = 0; data = '0;
    tick();
    rst = 0;
    mlock = 0; mrr = 0; mown = 0; mbeats = 0;
    for (int i = 0; i < N; i++) seq[i] = 0;
  endtask

  task automatic test_reset;
    rst = 1; valid = '1; last = '1; full = 0; set_data(0);
    #1;
    checks++;
    if (push !== 1'b0 || ready !== '0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_forced: push=%b ready=%b locked=%b, expected 0 0000 0", push, ready, locked);
    end
    tick();
    rst = 0;
    #1;
    checks++;
    if (push !== 1'b1 || gid !== 2'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: push=%b gid=%0d locked=%b, expected 1 0 0", push, gid, locked);
    end
    tick();
  endtask

  task automatic test_round_robin;
    int v[5] = '{15, 15, 15, 15, 15};
    int l[5] = '{15, 15, 15, 15, 15};
    int f[5] = '{0, 0, 0, 0, 0};
    int ep[5] = '{1, 1, 1, 1, 1};
    int eg[5] = '{0, 1, 2, 3, 0};
    int el[5] = '{0, 0, 0, 0, 0};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      logic [N-1:0] er;
      logic [IW+DW-1:0] ed;
      valid = N'(v[c]); last = N'(l[c]); full = f[c][0]; set_data(c);
      er = ep[c] != 0 ? N'(1) << eg[c] : '0;
      ed = {IW'(eg[c]), DW'(16 * (eg[c] + 1) + c)};
      #1;
      checks++;
      if (push !== ep[c][0] || ready !== er || gid !== IW'(eg[c]) || locked !== el[c][0] || (ep[c] != 0 && fdata !== ed)) begin
        errors++;
        $display("FAIL round_robin c%0d: push=%b ready=%b gid=%0d locked=%b data=%h, expected %b %b %0d %b %h",
                 c, push, ready, gid, locked, fdata, ep[c][0], er, eg[c], el[c][0], ed);
      end
      tick();
    end
  endtask

  task automatic test_burst_lock;
    int v[4] = '{4, 4, 4, 15};
    int l[4] = '{0, 0, 4, 15};
    int f[4] = '{0, 0, 0, 0};
    int ep[4] = '{1, 1, 1, 1};
    int eg[4] = '{2, 2, 2, 3};
    int el[4] = '{0, 1, 1, 0};
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      logic [N-1:0] er;
      logic [IW+DW-1:0] ed;
      valid = N'(v[c]); last = N'(l[c]); full = f[c][0]; set_data(c);
      er = ep[c] != 0 ? N'(1) << eg[c] : '0;
      ed = {IW'(eg[c]), DW'(16 * (eg[c] + 1) + c)};
      #1;
      checks++;
      if (push !== ep[c][0] || ready !== er || gid !== IW'(eg[c]) || locked !== el[c][0] || (ep[c] != 0 && fdata !== ed)) begin
        errors++;
        $display("FAIL burst_lock c%0d: push=%b ready=%b gid=%0d locked=%b data=%h, expected %b %b %0d %b %h",
                 c, push, ready, gid, locked, fdata, ep[c][0], er, eg[c], el[c][0], ed);
      end
      tick();
    end
  endtask

  task automatic test_forced_release;
    int v[6] = '{10, 10, 10, 10, 10, 10};
    int l[6] = '{8, 8, 8, 8, 8, 8};
    int f[6] = '{0, 0, 0, 0, 0, 0};
    int ep[6] = '{1, 1, 1, 1, 1, 1};
    int eg[6] = '{1, 1, 1, 1, 3, 1};
    int el[6] = '{0, 1, 1, 1, 0, 0};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      logic [N-1:0] er;
      logic [IW+DW-1:0] ed;
      valid = N'(v[c]); last = N'(l[c]); full = f[c][0]; set_data(c);
      er = ep[c] != 0 ? N'(1) << eg[c] : '0;
      ed = {IW'(eg[c]), DW'(16 * (eg[c] + 1) + c)};
      #1;
      checks++;
      if (push !== ep[c][0] || ready !== er || gid !== IW'(eg[c]) || locked !== el[c][0] || (ep[c] != 0 && fdata !== ed)) begin
        errors++;
        $display("FAIL forced_release c%0d: push=%b ready=%b gid=%0d locked=%b data=%h, expected %b %b %0d %b %h",
                 c, push, ready, gid, locked, fdata, ep[c][0], er, eg[c], el[c][0], ed);
      end
      tick();
    end
  endtask

  task automatic test_owner_stall;
    int v[6] = '{3, 2, 2, 2, 3, 3};
    int l[6] = '{2, 2, 2, 2, 3, 3};
    int f[6] = '{0, 0, 0, 0, 0, 0};
    int ep[6] = '{1, 0, 0, 0, 1, 1};
    int eg[6] = '{0, 0, 0, 0, 0, 1};
    int el[6] = '{0, 1, 1, 1, 1, 0};
    apply_reset();
    for (int c = 0; c < 6; c++) begin
      logic [N-1:0] er;
      logic [IW+DW-1:0] ed;
      valid = N'(v[c]); last = N'(l[c]); full = f[c][0]; set_data(c);
      er = ep[c] != 0 ? N'(1) << eg[c] : '0;
      ed = {IW'(eg[c]), DW'(16 * (eg[c] + 1) + c)};
      #1;
      checks++;
      if (push !== ep[c][0] || ready !== er || gid !== IW'(eg[c]) || locked !== el[c][0] || (ep[c] != 0 && fdata !== ed)) begin
        errors++;
        $display("FAIL owner_stall c%0d: push=%b ready=%b gid=%0d locked=%b data=%h, expected %b %b %0d %b %h",
                 c, push, ready, gid, locked, fdata, ep[c][0], er, eg[c], el[c][0], ed);
      end
      tick();
    end
  endtask

  task automatic test_full;
    int v[8] = '{15, 15, 15, 15, 15, 15, 15, 15};
    int l[8] = '{15, 15, 15, 15, 15, 15, 15, 15};
    int f[8] = '{0, 1, 1, 1, 1, 1, 0, 0};
    int ep[8] = '{1, 0, 0, 0, 0, 0, 1, 1};
    int eg[8] = '{0, 1, 1, 1, 1, 1, 1, 2};
    int el[8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      logic [N-1:0] er;
      logic [IW+DW-1:0] ed;
      valid = N'(v[c]); last = N'(l[c]); full = f[c][0]; set_data(c);
      er = ep[c] != 0 ? N'(1) << eg[c] : '0;
      ed = {IW'(eg[c]), DW'(16 * (eg[c] + 1) + c)};
      #1;
      checks++;
      if (push !== ep[c][0] || ready !== er || gid !== IW'(eg[c]) || locked !== el[c][0] || (ep[c] != 0 && fdata !== ed)) begin
        errors++;
        $display("FAIL fifo_full c%0d: push=%b ready=%b gid=%0d locked=%b data=%h, expected %b %b %0d %b %h",
                 c, push, ready, gid, locked, fdata, ep[c][0], er, eg[c], el[c][0], ed);
      end
      tick();
    end
    full = 0;
  endtask

  task automatic test_reset_mid_burst;
    int v[5] = '{3, 3, 3, 3, 3};
    int l[5] = '{0, 0, 0, 0, 0};
    int r[5] = '{0, 0, 1, 0, 0};
    int ep[5] = '{1, 1, 0, 1, 1};
    int eg[5] = '{0, 0, 0, 0, 0};
    int el[5] = '{0, 1, 0, 0, 1};
    apply_reset();
    for (int c = 0; c < 5; c++) begin
      logic [N-1:0] er;
      logic [IW+DW-1:0] ed;
      valid = N'(v[c]); last = N'(l[c]); rst = r[c][0]; set_data(c);
      er = ep[c] != 0 ? N'(1) << eg[c] : '0;
      ed = {IW'(eg[c]), DW'(16 * (eg[c] + 1) + c)};
      #1;
      checks++;
      if (push !== ep[c][0] || ready !== er || gid !== IW'(eg[c]) || locked !== el[c][0] || (ep[c] != 0 && fdata !== ed)) begin
        errors++;
        $display("FAIL reset_mid_burst c%0d: push=%b ready=%b gid=%0d locked=%b data=%h, expected %b %b %0d %b %h",
                 c, push, ready, gid, locked, fdata, ep[c][0], er, eg[c], el[c][0], ed);
      end
      tick();
    end
    rst = 0;
  endtask

  // Model tracks only "who holds the port and for how many words"; each producer streams an incrementing sequence
  task automatic test_random;
    apply_reset();
    for (int c = 0; c < 3000; c++) begin
      int w, eg;
      bit ep, el;
      logic [N-1:0] er;
      logic [IW+DW-1:0] ed;
      rst = $urandom_range(99) == 0;
      valid = N'($urandom);
      last = N'($urandom);
      full = $urandom_range(4) == 0;
      for (int i = 0; i < N; i++) data[i*DW +: DW] = DW'(seq[i]);
      w = -1;
      for (int k = 0; k < N; k++) if (w < 0 && valid[(mrr + k) % N]) w = (mrr + k) % N;
      eg = mlock ? mown : (w < 0 ? 0 : w);
      ep = !rst && !full && (mlock ? valid[mown] : w >= 0);
      el = !rst && mlock;
      er = ep ? N'(1) << eg : '0;
      ed = {IW'(eg), DW'(seq[eg])};
      #1;
      checks++;
      if (push !== ep || ready !== er || gid !== IW'(eg) || locked !== el || (ep && fdata !== ed)) begin
        errors++;
        $display("FAIL random c%0d: push=%b ready=%b gid=%0d locked=%b data=%h, expected %b %b %0d %b %h",
                 c, push, ready, gid, locked, fdata, ep, er, eg, el, ed);
      end
      if (rst) begin
        mlock = 0; mrr = 0; mown = 0; mbeats = 0;
      end else if (ep) begin
        seq[eg]++;
        if (!mlock) begin
          if (!last[eg] && MB > 1) begin
            mlock = 1; mown = eg; mbeats = 1;
          end else mrr = (eg + 1) % N;
        end else begin
          mbeats++;
          if (last[mown] || mbeats == MB) begin
            mlock = 0; mrr = (mown + 1) % N; mbeats = 0;
          end
        end
      end
      tick();
    end
    rst = 0;
  endtask

  initial begin
    rst = 1; valid = '0; last = '0; full = 0; data = '0;
    tick();
    test_reset();
    test_round_robin();
    test_burst_lock();
    test_forced_release();
    test_owner_stall();
    test_full();
    test_reset_mid_burst();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
